mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access stage of the five-stage pipeline; it drives the producing end of the MEM->WB bus consumed by the write-back stage.
- Captures the EXE->MEM bundle and, for loads and stores, runs a request/response transaction with the data cache port.
- Aligns and extends load data, then presents a completed MEM->WB bundle under a valid/over/allow_in handshake.
- Honours the write-back cancel (syscall/eret flush), including draining an in-flight cache transaction.

Parameters:
- EXE_MEM_W, 154, EXE->MEM bus width.
- MEM_WB_W, 118, MEM->WB bus width.

Ports:
- clk  in  1  clock.
- resetn  in  1  reset. One clock; reset is asynchronous and active-low.
- EXE_over  in  1  EXE has a finished instruction to hand over.
- EXE_MEM_bus  in  154  {ls_ctrl[3:0]={load,store,word,sign}, store_data[31:0], exe_result[31:0], lo_result[31:0], hi_write, lo_write, mfhi, mflo, mtc0, mfc0, cp0r_addr[7:0], syscall, eret, wen, wdest[4:0], pc[31:0]}.
- WB_allow_in  in  1  WB accepts a bundle this cycle.
- cancel  in  1  flush from WB.
- MEM_allow_in  out  1  stage can capture this cycle.
- MEM_valid  out  1  stage holds a live instruction.
- MEM_over  out  1  bundle complete; MEM_WB_bus is valid.
- MEM_WB_bus  out  118  {wen, wdest, mem_result, lo_result, hi_write, lo_write, mfhi, mflo, mtc0, mfc0, cp0r_addr, syscall, eret, pc}.
- data_req  out  1  cache request.
- data_wr  out  1  1 = store.
- data_size  out  2  0 = byte, 2 = word.
- data_wstrb  out  4  byte enables.
- data_addr  out  32  address.
- data_wdata  out  32  store data.
- data_addr_ok  in  1  request accepted.
- data_data_ok  in  1  response / store acknowledgement.
- data_rdata  in  32  load data.
- MEM_wdest  out  5  forwarding destination; 0 when not valid.
- MEM_fwd_wdata  out  32  forwarding data; valid only when MEM_over.
- MEM_pc  out  32  captured pc, for display.

Behaviour:
- Reset (async, resetn=0): state IDLE, MEM_valid=0, data_req=0; MEM_over=0, MEM_wdest=0, MEM_allow_in=1. Bus register contents are don't-care.
- Capture: on the clk edge with EXE_over & MEM_allow_in & !cancel, the bus register loads EXE_MEM_bus and MEM_valid is set to 1.
- If no capture occurs and MEM_over & WB_allow_in, MEM_valid clears.
- MEM_allow_in = !MEM_valid | (MEM_over & WB_allow_in).
- FSM states: IDLE, REQ, WAIT, DONE, DRAIN.
  - Capture of load/store -> REQ. Capture of any other instruction -> DONE.
  - REQ: data_req=1 and all request fields held stable. On data_addr_ok -> WAIT.
  - WAIT: on data_data_ok, load result is registered -> DONE.
  - DONE: MEM_over=1 combinationally. Leaves on handoff: -> REQ/DONE if a new capture happens in the same cycle, otherwise -> IDLE.
- Latency: non-memory instruction MEM_over in the cycle after capture. Memory instruction minimum 3 cycles (REQ with addr_ok, WAIT with data_ok, DONE).
- Stores complete only on data_data_ok.
- Address and size: data_addr = {exe_result[31:2],2'b00} for word accesses, exe_result for byte accesses. Word accesses ignore misalignment.
- sb: data_wstrb = 4'b0001 << addr[1:0]; data_wdata = byte replicated ×4.
- sw: data_wstrb = 4'hF.
- lb/lbu: byte lane addr[1:0] of data_rdata; sign-extended when sign=1, zero-extended otherwise.
- lw: data_rdata passed through.
- mem_result = load data for loads, exe_result otherwise.
- Cancel:
  - In REQ before data_addr_ok: drop data_req, -> IDLE, MEM_valid=0.
  - In REQ with data_addr_ok in the same cycle, or in WAIT: -> DRAIN. MEM_valid=0, MEM_allow_in=0 until data_data_ok, then -> IDLE; the response is discarded.
  - Coincident data_data_ok in WAIT: -> IDLE directly.
  - In DONE: -> IDLE.
- Simultaneous handoff and capture: allowed in one cycle (back-to-back throughput).
- Async reset mid-transaction: returns to IDLE. The cache side is reset by the same resetn.

Decomposition:
- Shared package mem_defs:
  - bus widths, and field offsets for both buses;
  - FSM state encoding;
  - size codes SZ_BYTE=2'd0, SZ_WORD=2'd2.
- One combinational sub-module mem_align: addr[1:0], ls_ctrl, store_data, rdata -> wstrb, wdata, load_result.

Test Plan:
1. Non-memory add, exe_result=32'h1234, wen=1, wdest=5, WB_allow_in=1 -> MEM_over in the next cycle, mem_result=32'h1234, MEM_wdest=5.
2. lb from addr 0x103, rdata=32'h80AA_BBCC, sign=1, addr_ok/data_ok immediate -> data_size=0, mem_result=32'hFFFF_FF80; the lbu variant gives 32'h0000_0080.
3. sb to addr 0x102, store_data=32'h0000_00A5 -> data_wstrb=4'b0100, data_wdata=32'hA5A5_A5A5, data_wr=1, MEM_over after data_ok.
4. lw with addr_ok delayed 3 cycles and data_ok delayed 2 more -> data_req and data_addr held stable throughout, MEM_allow_in=0, MEM_over 1 cycle after data_ok.
5. cancel in WAIT, data_ok 2 cycles later -> no MEM_over, MEM_allow_in=0 until data_ok, then a new capture is accepted and its result is not corrupted by the drained response.
6. resetn pulsed low while in REQ -> data_req=0 and MEM_valid=0 immediately, without waiting for clk.

Source files
------------

// File: rtl/mem_defs.sv
// Shared definitions for the memory-access stage: bus geometry, field offsets,
// FSM encoding and cache size codes.
package mem_defs;

    localparam int EXE_MEM_WIDTH = 154;
    localparam int MEM_WB_WIDTH  = 118;

    // EXE->MEM field offsets (lsb of each field)
    localparam int EM_LS_LO    = 150;
    localparam int EM_SD_LO    = 118;
    localparam int EM_EXE_LO   = 86;
    localparam int EM_LORES_LO = 54;
    localparam int EM_FLAGS_LO = 38;   // hi_write..eret, 16 bits
    localparam int EM_WEN      = 37;
    localparam int EM_WDEST_LO = 32;
    localparam int EM_PC_LO    = 0;

    // MEM->WB field offsets (lsb of each field)
    localparam int WB_WEN      = 117;
    localparam int WB_WDEST_LO = 112;
    localparam int WB_RES_LO   = 80;
    localparam int WB_LORES_LO = 48;
    localparam int WB_FLAGS_LO = 32;
    localparam int WB_PC_LO    = 0;

    // ls_ctrl bit positions
    localparam int LS_LOAD  = 3;
    localparam int LS_STORE = 2;
    localparam int LS_WORD  = 1;
    localparam int LS_SIGN  = 0;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DONE,
        ST_DRAIN
    } mem_state_e;

    function automatic logic is_mem_op(input logic [3:0] ls);
        return ls[LS_LOAD] | ls[LS_STORE];
    endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane steering between the pipeline and the data cache port:
// store strobes/replication and load lane selection with sign/zero extension.
module mem_align
    import mem_defs::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [3:0]  ls_ctrl,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic [31:0] load_result
);

    logic [7:0] lane;

    always_comb begin
        wstrb = 4'h0;
        wdata = store_data;
        if (ls_ctrl[LS_STORE]) begin
            if (ls_ctrl[LS_WORD]) begin
                wstrb = 4'hF;
            end else begin
                wstrb = 4'b0001 << addr_lo;
                wdata = {4{store_data[7:0]}};
            end
        end
    end

    always_comb begin
        lane        = rdata[{addr_lo, 3'b000} +: 8];
        load_result = ls_ctrl[LS_WORD] ? rdata
                    : {{24{ls_ctrl[LS_SIGN] & lane[7]}}, lane};
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: holds one instruction, runs the cache
// request/response for loads and stores, and hands the result to WB.
module mem_stage
    import mem_defs::*;
#(
    parameter int EXE_MEM_W = EXE_MEM_WIDTH,
    parameter int MEM_WB_W  = MEM_WB_WIDTH
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 EXE_over,
    input  logic [EXE_MEM_W-1:0] EXE_MEM_bus,
    input  logic                 WB_allow_in,
    input  logic                 cancel,
    output logic                 MEM_allow_in,
    output logic                 MEM_valid,
    output logic                 MEM_over,
    output logic [MEM_WB_W-1:0]  MEM_WB_bus,
    output logic                 data_req,
    output logic                 data_wr,
    output logic [1:0]           data_size,
    output logic [3:0]           data_wstrb,
    output logic [31:0]          data_addr,
    output logic [31:0]          data_wdata,
    input  logic                 data_addr_ok,
    input  logic                 data_data_ok,
    input  logic [31:0]          data_rdata,
    output logic [4:0]           MEM_wdest,
    output logic [31:0]          MEM_fwd_wdata,
    output logic [31:0]          MEM_pc
);

    mem_state_e           state_q, state_d;
    logic                 valid_q, valid_d;
    logic [EXE_MEM_W-1:0] bus_q, bus_d;
    logic [31:0]          load_q, load_d;

    logic [3:0]  ls_ctrl;
    logic [31:0] store_data, exe_result, lo_result, pc, mem_result, load_result;
    logic [15:0] flags;
    logic        wen;
    logic [4:0]  wdest;
    logic        handoff, capture;
    mem_state_e  capture_state;

    assign ls_ctrl    = bus_q[EM_LS_LO +: 4];
    assign store_data = bus_q[EM_SD_LO +: 32];
    assign exe_result = bus_q[EM_EXE_LO +: 32];
    assign lo_result  = bus_q[EM_LORES_LO +: 32];
    assign flags      = bus_q[EM_FLAGS_LO +: 16];
    assign wen        = bus_q[EM_WEN];
    assign wdest      = bus_q[EM_WDEST_LO +: 5];
    assign pc         = bus_q[EM_PC_LO +: 32];

    assign MEM_over      = (state_q == ST_DONE);
    assign MEM_valid     = valid_q;
    assign handoff       = MEM_over & WB_allow_in;
    // DRAIN blocks capture: the orphaned response must not be taken as the next one's
    assign MEM_allow_in  = (state_q != ST_DRAIN) & (~valid_q | handoff);
    assign capture       = EXE_over & MEM_allow_in & ~cancel;
    assign capture_state = is_mem_op(EXE_MEM_bus[EM_LS_LO +: 4]) ? ST_REQ : ST_DONE;

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        bus_d   = bus_q;
        load_d  = load_q;

        if (capture) begin
            bus_d   = EXE_MEM_bus;
            valid_d = 1'b1;
        end else if (cancel | handoff) begin
            valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE:  if (capture) state_d = capture_state;
            ST_REQ: begin
                if (cancel)            state_d = data_addr_ok ? ST_DRAIN : ST_IDLE;
                else if (data_addr_ok) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cancel) begin
                    state_d = data_data_ok ? ST_IDLE : ST_DRAIN;
                end else if (data_data_ok) begin
                    load_d  = load_result;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (cancel)       state_d = ST_IDLE;
                else if (handoff) state_d = capture ? capture_state : ST_IDLE;
            end
            ST_DRAIN: if (data_data_ok) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            bus_q   <= '0;
            load_q  <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            bus_q   <= bus_d;
            load_q  <= load_d;
        end
    end

    mem_align u_align (
        .addr_lo     (exe_result[1:0]),
        .ls_ctrl     (ls_ctrl),
        .store_data  (store_data),
        .rdata       (data_rdata),
        .wstrb       (data_wstrb),
        .wdata       (data_wdata),
        .load_result (load_result)
    );

    // Request fields come straight from the held bundle, so they stay stable in REQ
    assign data_req  = (state_q == ST_REQ);
    assign data_wr   = ls_ctrl[LS_STORE];
    assign data_size = ls_ctrl[LS_WORD] ? SZ_WORD : SZ_BYTE;
    assign data_addr = ls_ctrl[LS_WORD] ? {exe_result[31:2], 2'b00} : exe_result;

    assign mem_result    = ls_ctrl[LS_LOAD] ? load_q : exe_result;
    assign MEM_WB_bus    = {wen, wdest, mem_result, lo_result, flags, pc};
    assign MEM_wdest     = valid_q ? wdest : 5'd0;
    assign MEM_fwd_wdata = mem_result;
    assign MEM_pc        = pc;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a cache responder, an expectation model
// of completed bundles/cache requests, and a per-cycle compare process.
module tb_mem_stage;

    logic         clk = 1'b0;
    logic         resetn;
    logic         EXE_over;
    logic [153:0] EXE_MEM_bus;
    logic         WB_allow_in;
    logic         cancel;
    logic         MEM_allow_in, MEM_valid, MEM_over;
    logic [117:0] MEM_WB_bus;
    logic         data_req, data_wr;
    logic [1:0]   data_size;
    logic [3:0]   data_wstrb;
    logic [31:0]  data_addr, data_wdata;
    logic         data_addr_ok, data_data_ok;
    logic [31:0]  data_rdata;
    logic [4:0]   MEM_wdest;
    logic [31:0]  MEM_fwd_wdata, MEM_pc;

    mem_stage dut (
        .clk(clk), .resetn(resetn), .EXE_over(EXE_over), .EXE_MEM_bus(EXE_MEM_bus),
        .WB_allow_in(WB_allow_in), .cancel(cancel), .MEM_allow_in(MEM_allow_in),
        .MEM_valid(MEM_valid), .MEM_over(MEM_over), .MEM_WB_bus(MEM_WB_bus),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .MEM_wdest(MEM_wdest), .MEM_fwd_wdata(MEM_fwd_wdata), .MEM_pc(MEM_pc)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  size;
        logic        wr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } req_t;

    logic [117:0] exp_wb_q[$];
    req_t         exp_req_q[$];
    logic [31:0]  resp_q[$];

    // Reference model: what the completed instruction must deliver
    function automatic logic [31:0] model_result(input logic [3:0] ls, input logic [31:0] exe,
                                                 input logic [31:0] rdata);
        logic [31:0] b;
        if (!ls[3]) return exe;
        if (ls[1])  return rdata;
        b = (rdata >> (8 * exe[1:0])) & 32'hFF;
        if (ls[0] && b[7]) return b | 32'hFFFF_FF00;
        return b;
    endfunction

    function automatic logic [153:0] mk(input logic [3:0] ls, input logic [31:0] sd,
                                        input logic [31:0] exe, input logic [4:0] wd,
                                        input logic [31:0] pc);
        return {ls, sd, exe, ~pc, pc[15:0], 1'b1, wd, pc};
    endfunction

    // Cache responder: addr_ok after addr_dly REQ cycles, data_ok data_dly cycles later
    int addr_dly = 0, data_dly = 0;
    int r_phase = 0, r_cnt = 0;
    initial begin
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        data_rdata   = 32'hDEAD_BEEF;
        forever begin
            @(posedge clk); #1;
            data_addr_ok = 1'b0;
            data_data_ok = 1'b0;
            data_rdata   = 32'hDEAD_BEEF;
            if (!resetn) begin
                r_phase = 0;
            end else begin
                if (r_phase == 0 && data_req) begin
                    r_phase = 1;
                    r_cnt   = addr_dly;
                end
                if (r_phase == 1) begin
                    if (!data_req) r_phase = 0;
                    else if (r_cnt == 0) begin
                        data_addr_ok = 1'b1;
                        r_phase      = 2;
                        r_cnt        = data_dly;
                    end else r_cnt--;
                end else if (r_phase == 2) begin
                    if (r_cnt == 0) begin
                        data_data_ok = 1'b1;
                        data_rdata   = (resp_q.size() != 0) ? resp_q.pop_front() : 32'hDEAD_BEEF;
                        r_phase      = 0;
                    end else r_cnt--;
                end
            end
        end
    end

    // Compare process: cache requests, request stability and every WB handoff
    logic        prev_pend = 1'b0;
    logic [31:0] prev_addr = '0;
    initial begin
        req_t         r;
        logic [117:0] e;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                prev_pend = 1'b0;
            end else begin
                if (prev_pend) begin
                    chk("req_held", data_req, 1'b1);
                    chk("addr_held", data_addr, prev_addr);
                end
                prev_pend = data_req && !data_addr_ok && !cancel;
                prev_addr = data_addr;
                if (data_req && data_addr_ok) begin
                    if (exp_req_q.size() == 0) chk("req_unexpected", data_addr_ok, 1'b0);
                    else begin
                        r = exp_req_q.pop_front();
                        chk("req_addr", data_addr, r.addr);
                        chk("req_size", data_size, r.size);
                        chk("req_wr", data_wr, r.wr);
                        if (r.wr) begin
                            chk("req_wstrb", data_wstrb, r.wstrb);
                            chk("req_wdata", data_wdata, r.wdata);
                        end
                    end
                end
                if (MEM_over) begin
                    if (exp_wb_q.size() == 0) chk("over_unexpected", MEM_over, 1'b0);
                    else begin
                        e = exp_wb_q[0];
                        chk("wb_bus", MEM_WB_bus, e);
                        chk("fwd_wdest", MEM_wdest, e[116:112]);
                        chk("fwd_wdata", MEM_fwd_wdata, e[111:80]);
                        if (WB_allow_in) void'(exp_wb_q.pop_front());
                    end
                end
            end
        end
    end

    int acc_wait;
    task automatic send(input logic [153:0] b);
        bit ok = 0;
        acc_wait = 0;
        EXE_MEM_bus = b;
        EXE_over    = 1'b1;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge clk);
            acc_wait++;
            if (MEM_allow_in && !cancel) ok = 1;
        end
        chk("send_accept", ok, 1'b1);
        @(posedge clk); #1;
        EXE_over = 1'b0;
    endtask

    // mode 0: completes; 1: cancelled after address accepted; 2: request never accepted
    task automatic issue(input logic [3:0] ls, input logic [31:0] sd, input logic [31:0] exe,
                         input logic [4:0] wd, input logic [31:0] pc, input logic [31:0] rdata,
                         input int mode);
        req_t r;
        if (mode == 0)
            exp_wb_q.push_back({1'b1, wd, model_result(ls, exe, rdata), ~pc, pc[15:0], pc});
        if (ls[3] || ls[2]) begin
            r.addr  = ls[1] ? {exe[31:2], 2'b00} : exe;
            r.size  = ls[1] ? 2'd2 : 2'd0;
            r.wr    = ls[2];
            r.wstrb = ls[1] ? 4'hF : (4'b0001 << exe[1:0]);
            r.wdata = ls[1] ? sd : {4{sd[7:0]}};
            exp_req_q.push_back(r);
            if (mode != 2) resp_q.push_back(rdata);
        end
        send(mk(ls, sd, exe, wd, pc));
    endtask

    task automatic wait_over(output int cyc, output int leak);
        cyc  = 0;
        leak = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (MEM_over) begin
                cyc = k;
                break;
            end
            if (MEM_allow_in) leak++;
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, leak;
        resetn = 1'b0; EXE_over = 1'b0; EXE_MEM_bus = '0; WB_allow_in = 1'b1; cancel = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid", MEM_valid, 1'b0);
        chk("rst_req", data_req, 1'b0);
        chk("rst_over", MEM_over, 1'b0);
        chk("rst_wdest", MEM_wdest, 5'd0);
        chk("rst_allow", MEM_allow_in, 1'b1);
        step();
        resetn = 1'b1;

        // non-memory instruction
        issue(4'b0000, 32'h0, 32'h1234, 5'd5, 32'hBFC0_0000, 32'h0, 0);
        wait_over(cyc, leak);
        chk("t1_latency", cyc, 1);
        chk("t1_result", MEM_WB_bus[111:80], 32'h1234);
        chk("t1_wdest", MEM_wdest, 5'd5);
        step();
        @(negedge clk);
        chk("idle_wdest", MEM_wdest, 5'd0);
        chk("idle_valid", MEM_valid, 1'b0);
        step();

        // lb / lbu with immediate cache responses
        addr_dly = 0; data_dly = 0;
        issue(4'b1001, 32'h0, 32'h103, 5'd6, 32'hBFC0_0004, 32'h80AA_BBCC, 0);
        chk("t2_size", data_size, 2'd0);
        wait_over(cyc, leak);
        chk("t2_latency", cyc, 3);
        chk("t2_lb", MEM_WB_bus[111:80], 32'hFFFF_FF80);
        step();
        issue(4'b1000, 32'h0, 32'h103, 5'd6, 32'hBFC0_0008, 32'h80AA_BBCC, 0);
        wait_over(cyc, leak);
        chk("t2_lbu", MEM_WB_bus[111:80], 32'h0000_0080);
        step();
        issue(4'b1001, 32'h0, 32'h101, 5'd7, 32'hBFC0_000C, 32'h80AA_BBCC, 0);
        wait_over(cyc, leak);
        chk("t2_lb_lane1", MEM_WB_bus[111:80], 32'hFFFF_FFBB);
        step();

        // sb and misaligned sw
        issue(4'b0100, 32'h0000_00A5, 32'h102, 5'd0, 32'hBFC0_0010, 32'h0, 0);
        chk("t3_wstrb", data_wstrb, 4'b0100);
        chk("t3_wdata", data_wdata, 32'hA5A5_A5A5);
        chk("t3_wr", data_wr, 1'b1);
        wait_over(cyc, leak);
        chk("t3_latency", cyc, 3);
        step();
        issue(4'b0110, 32'h1234_5678, 32'h107, 5'd0, 32'hBFC0_0014, 32'h0, 0);
        wait_over(cyc, leak);
        step();

        // lw with delayed handshakes
        addr_dly = 3; data_dly = 2;
        issue(4'b1010, 32'h0, 32'h200, 5'd9, 32'hBFC0_0018, 32'hCAFE_F00D, 0);
        wait_over(cyc, leak);
        chk("t4_latency", cyc, 8);
        chk("t4_no_allow", leak, 0);
        chk("t4_result", MEM_WB_bus[111:80], 32'hCAFE_F00D);
        step();

        // WB back-pressure, then back-to-back non-memory traffic
        WB_allow_in = 1'b0;
        issue(4'b0000, 32'h0, 32'h55, 5'd3, 32'hBFC0_001C, 32'h0, 0);
        @(negedge clk);
        chk("hold_over", MEM_over, 1'b1);
        chk("hold_allow", MEM_allow_in, 1'b0);
        step();
        WB_allow_in = 1'b1;
        issue(4'b0000, 32'h0, 32'h66, 5'd4, 32'hBFC0_0020, 32'h0, 0);
        chk("b2b_wait0", acc_wait, 1);
        issue(4'b0000, 32'h0, 32'h77, 5'd8, 32'hBFC0_0024, 32'h0, 0);
        chk("b2b_wait1", acc_wait, 1);
        issue(4'b0000, 32'h0, 32'h88, 5'd10, 32'hBFC0_0028, 32'h0, 0);
        chk("b2b_wait2", acc_wait, 1);
        wait_over(cyc, leak);
        step();

        // cancel in WAIT, response arrives while draining
        addr_dly = 0; data_dly = 2;
        issue(4'b1010, 32'h0, 32'h300, 5'd11, 32'hBFC0_002C, 32'h1111_1111, 1);
        step();
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        @(negedge clk);
        chk("t5_valid", MEM_valid, 1'b0);
        chk("t5_allow", MEM_allow_in, 1'b0);
        chk("t5_over", MEM_over, 1'b0);
        data_dly = 0;
        issue(4'b1010, 32'h0, 32'h304, 5'd12, 32'hBFC0_0030, 32'h2222_2222, 0);
        chk("t5_drain_wait", acc_wait, 2);
        wait_over(cyc, leak);
        chk("t5_result", MEM_WB_bus[111:80], 32'h2222_2222);
        step();

        // cancel in REQ before the address is accepted
        addr_dly = 5;
        issue(4'b1010, 32'h0, 32'h400, 5'd13, 32'hBFC0_0034, 32'h0, 2);
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        chk("t7_req", data_req, 1'b0);
        chk("t7_valid", MEM_valid, 1'b0);
        chk("t7_allow", MEM_allow_in, 1'b1);
        exp_req_q.delete();
        step();

        // asynchronous reset while requesting
        addr_dly = 10;
        issue(4'b1010, 32'h0, 32'h500, 5'd14, 32'hBFC0_0038, 32'h0, 2);
        @(negedge clk);
        chk("t6_req_before", data_req, 1'b1);
        #2 resetn = 1'b0;
        #1;
        chk("t6_req", data_req, 1'b0);
        chk("t6_valid", MEM_valid, 1'b0);
        chk("t6_allow", MEM_allow_in, 1'b1);
        @(negedge clk);
        step();
        resetn = 1'b1;
        exp_req_q.delete();
        step();
        addr_dly = 0; data_dly = 0;
        issue(4'b1010, 32'h0, 32'h600, 5'd15, 32'hBFC0_003C, 32'h3333_4444, 0);
        wait_over(cyc, leak);
        chk("t6_recover", MEM_WB_bus[111:80], 32'h3333_4444);
        step();
        repeat (2) step();

        chk("wb_queue_empty", exp_wb_q.size(), 0);
        chk("req_queue_empty", exp_req_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
